// File: rtl/tx_fifo_packer.sv
// ----------------------------------------------------------------------------
// tx_fifo_packer
//
// Packs a narrow valid/ready word stream into FIFO-wide entries for the
// write side of the TX async FIFO. PACK_RATIO words make one entry. A word
// flagged with in_last closes a partially filled entry early. Slot 0 sits
// in the least significant bits of the entry, and unfilled upper slots
// are zero.
//
// An entry passes through two stages. The assembly register collects
// words. The hold register presents a finished entry to the FIFO. With
// both stages full, at most two entries are buffered internally.
//
// Ports
//   w_clk     in   write-domain clock, posedge
//   w_rst     in   synchronous active-high reset
//   in_valid  in   input word valid
//   in_data   in   input word
//   in_last   in   final word of a burst; flushes a partial entry
//   in_ready  out  a word can be accepted this cycle (registered)
//   wfull     in   FIFO full flag
//   winc      out  FIFO write increment; one entry per high cycle
//   wdata     out  entry presented to the FIFO
//   wcnt      out  number of valid words in wdata (1..PACK_RATIO)
//
// asm_state | meaning
// ----------+---------------------------------------------------------------
// FILL      | assembly accepting words; in_ready=1
// PEND      | assembly holds a finished entry waiting for hold; in_ready=0
// ----------------------------------------------------------------------------
module tx_fifo_packer #(
    parameter int IN_WIDTH   = 32,
    parameter int PACK_RATIO = 4,
    parameter int CNT_WIDTH  = $clog2(PACK_RATIO + 1)
) (
    input  logic                           w_clk,
    input  logic                           w_rst,
    input  logic                           in_valid,
    input  logic [IN_WIDTH-1:0]            in_data,
    input  logic                           in_last,
    output logic                           in_ready,
    input  logic                           wfull,
    output logic                           winc,
    output logic [IN_WIDTH*PACK_RATIO-1:0] wdata,
    output logic [CNT_WIDTH-1:0]           wcnt
);

    localparam int                   ENTRY_W   = IN_WIDTH * PACK_RATIO;
    localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(PACK_RATIO - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PEND = 1'b1
    } asm_state_t;

    asm_state_t           asm_state;
    logic [ENTRY_W-1:0]   asm_data;
    logic [CNT_WIDTH-1:0] slot_cnt;
    logic [ENTRY_W-1:0]   hold_data;
    logic [CNT_WIDTH-1:0] hold_cnt;
    logic                 hold_valid;
    logic                 in_ready_q;

    logic                 accept;
    logic                 complete;
    logic                 hold_free;
    logic [ENTRY_W-1:0]   merged;

    // in_ready is a flop, so it never depends on the input-side signals.
    // It only reads 1 while asm_state is FILL.
    assign in_ready  = in_ready_q;
    assign accept    = in_valid && in_ready_q;
    assign complete  = accept && ((slot_cnt == LAST_SLOT) || in_last);

    assign winc      = hold_valid && !wfull;
    assign hold_free = !hold_valid || winc;
    assign wdata     = hold_data;
    assign wcnt      = hold_cnt;

    // Assembly contents with the incoming word dropped into its slot. The
    // slots above slot_cnt are always zero, because assembly is cleared
    // on every transfer to hold.
    always_comb begin
        merged = asm_data;
        merged[int'(slot_cnt) * IN_WIDTH +: IN_WIDTH] = in_data;
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            asm_state  <= FILL;
            asm_data   <= '0;
            slot_cnt   <= '0;
            hold_data  <= '0;
            hold_cnt   <= '0;
            hold_valid <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            // A drain empties hold unless a refill below overrides it
            // in the same cycle.
            if (winc) begin
                hold_valid <= 1'b0;
            end

            case (asm_state)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        if (complete) begin
                            if (hold_free) begin
                                hold_data  <= merged;
                                hold_cnt   <= slot_cnt + CNT_ONE;
                                hold_valid <= 1'b1;
                                asm_data   <= '0;
                                slot_cnt   <= '0;
                            end else begin
                                // slot_cnt is kept, so the count is still
                                // available when the entry moves to hold.
                                asm_data   <= merged;
                                asm_state  <= PEND;
                                in_ready_q <= 1'b0;
                            end
                        end else begin
                            asm_data <= merged;
                            slot_cnt <= slot_cnt + CNT_ONE;
                        end
                    end
                end

                PEND: begin
                    if (hold_free) begin
                        hold_data  <= asm_data;
                        hold_cnt   <= slot_cnt + CNT_ONE;
                        hold_valid <= 1'b1;
                        asm_data   <= '0;
                        slot_cnt   <= '0;
                        asm_state  <= FILL;
                        in_ready_q <= 1'b1;
                    end
                end

                default: begin
                    asm_state  <= FILL;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
